// File: rtl/fdivs_pkg.sv
// Shared constants and types for the fractional signed divider.
//   OpWidth  - width of the Q1.7 divisor and quotient
//   DvdWidth - width of the Q1.15 dividend
//   NumIter  - quotient bits produced, one per CALC cycle
package fdivs_pkg;

  localparam int unsigned OpWidth  = 8;
  localparam int unsigned DvdWidth = 16;
  localparam int unsigned NumIter  = 16;

  // Partial remainder is always below the doubled divisor (at most 256), so 9 bits suffice.
  localparam int unsigned RemWidth = OpWidth + 1;
  localparam int unsigned CntWidth = $clog2(NumIter);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } fdivs_state_e;

endpackage

// File: rtl/fdivs_step_v.sv
// One restoring-division step (combinational).
//   rem      - current partial remainder
//   din      - next dividend bit shifted into the remainder
//   dvs      - divisor magnitude (already doubled)
//   rem_next - partial remainder after the trial subtraction
//   q        - quotient bit (1 when the subtraction did not underflow)
module fdivs_step_v
  import fdivs_pkg::*;
(
  input  logic [RemWidth-1:0] rem,
  input  logic                din,
  input  logic [RemWidth-1:0] dvs,
  output logic [RemWidth-1:0] rem_next,
  output logic                q
);

  logic [RemWidth:0]   shifted;
  logic [RemWidth+1:0] trial;
  logic                unused_trial;

  assign shifted  = {rem, din};
  assign trial    = {1'b0, shifted} - {2'b00, dvs};
  assign q        = ~trial[RemWidth+1];
  // A successful trial is below dvs, so its top magnitude bit is always zero.
  assign rem_next = q ? trial[RemWidth-1:0] : shifted[RemWidth-1:0];
  assign unused_trial = trial[RemWidth];

endmodule

// File: rtl/fdivs_v.sv
// Signed fractional divider: Q1.7 = Q1.15 / (2 * Q1.7), truncated toward zero,
// so that fractional-multiplying the quotient by the divisor gives back the dividend.
// Sign-magnitude restoring division, one quotient bit per clock.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_start        - start request, accepted only when idle
//   i_r1, i_r0     - dividend high/low byte (signed Q1.15)
//   i_rr           - divisor (signed Q1.7)
//   o_rd, o_ovf    - quotient and saturation/divide-by-zero flag, held until the next result
//   o_busy         - division in progress
//   o_done         - one-cycle result strobe
module fdivs_v
  import fdivs_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_r1,
  input  logic [7:0] i_r0,
  input  logic [7:0] i_rr,
  output logic [7:0] o_rd,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ovf
);

  fdivs_state_e          state_q;
  logic [CntWidth-1:0]   cnt_q;
  // Holds the dividend magnitude; quotient bits shift in from the bottom.
  logic [DvdWidth-1:0]   dvd_q;
  logic [RemWidth-1:0]   rem_q;
  logic [RemWidth-1:0]   dvs_q;
  logic                  neg_q;
  logic                  dneg_q;
  logic                  dzero_q;

  logic [DvdWidth-1:0]   dvd_in;
  logic [DvdWidth-1:0]   dvd_abs;
  logic [OpWidth-1:0]    rr_abs;
  logic [RemWidth-1:0]   rem_next;
  logic                  q_bit;

  logic [OpWidth-1:0]    mag_lo;
  logic                  over;
  logic                  exact_min;
  logic [OpWidth-1:0]    fin_rd;
  logic                  fin_ovf;

  assign dvd_in  = {i_r1, i_r0};
  assign dvd_abs = dvd_in[DvdWidth-1] ? (~dvd_in + 16'd1) : dvd_in;
  assign rr_abs  = i_rr[OpWidth-1] ? (~i_rr + 8'd1) : i_rr;

  fdivs_step_v u_step (
    .rem      (rem_q),
    .din      (dvd_q[DvdWidth-1]),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .q        (q_bit)
  );

  // Result formatting: saturate, except that a magnitude of exactly 128 is representable
  // when the sign is negative.
  always_comb begin
    fin_rd    = '0;
    fin_ovf   = 1'b0;
    mag_lo    = dvd_q[OpWidth-1:0];
    over      = dvd_q > 16'd127;
    exact_min = neg_q && (dvd_q == 16'd128);
    if (dzero_q) begin
      fin_rd  = dneg_q ? 8'h80 : 8'h7F;
      fin_ovf = 1'b1;
    end else if (over && !exact_min) begin
      fin_rd  = neg_q ? 8'h80 : 8'h7F;
      fin_ovf = 1'b1;
    end else begin
      fin_rd  = neg_q ? (~mag_lo + 8'd1) : mag_lo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      dzero_q <= 1'b0;
      o_rd    <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            dvd_q   <= dvd_abs;
            rem_q   <= '0;
            dvs_q   <= {rr_abs, 1'b0};
            neg_q   <= i_r1[7] ^ i_rr[7];
            dneg_q  <= i_r1[7];
            dzero_q <= (i_rr == 8'h00);
            cnt_q   <= '0;
            o_busy  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          dvd_q <= {dvd_q[DvdWidth-2:0], q_bit};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntWidth'(NumIter - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          o_rd    <= fin_rd;
          o_ovf   <= fin_ovf;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
